// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared VGA timing definitions used by the scanout path.
//   - Default 640x480@60 timing values (pixels / lines).
//   - Sync polarity constants: both syncs are active-low for this mode.
// Totals are derived from the four components in each direction so that the
// modules can recompute them from overridden parameters.
package vga_timing_pkg;

  localparam int DEF_HOR_ACTIVE_PIXELS = 640;
  localparam int DEF_HOR_FRONT_PORCH   = 16;
  localparam int DEF_HOR_SYNC          = 96;
  localparam int DEF_HOR_BACK_PORCH    = 48;

  localparam int DEF_VER_ACTIVE_PIXELS = 480;
  localparam int DEF_VER_FRONT_PORCH   = 10;
  localparam int DEF_VER_SYNC          = 2;
  localparam int DEF_VER_BACK_PORCH    = 33;

  localparam int DEF_H_TOTAL = DEF_HOR_ACTIVE_PIXELS + DEF_HOR_FRONT_PORCH +
                               DEF_HOR_SYNC + DEF_HOR_BACK_PORCH;
  localparam int DEF_V_TOTAL = DEF_VER_ACTIVE_PIXELS + DEF_VER_FRONT_PORCH +
                               DEF_VER_SYNC + DEF_VER_BACK_PORCH;

  // Level driven on hsync/vsync while inside the sync pulse, and otherwise.
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

endpackage

// File: rtl/vga_counter.sv
// vga_counter
// Stage-0 raster position counters with wrap and region decode.
// Ports:
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   visible      : current (h,v) is inside the visible area
//   in_hsync     : current h is inside the horizontal sync pulse
//   in_vsync     : current v is inside the vertical sync pulse
//   frame_first  : current (h,v) is (0,0)
//   frame_last   : current (h,v) is (H_TOTAL-1, V_TOTAL-1)
// All outputs are decoded from the registered counters only.
module vga_counter
  import vga_timing_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE_PIXELS,
  parameter int VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
  parameter int HOR_FRONT_PORCH   = DEF_HOR_FRONT_PORCH,
  parameter int HOR_SYNC          = DEF_HOR_SYNC,
  parameter int HOR_BACK_PORCH    = DEF_HOR_BACK_PORCH,
  parameter int VER_FRONT_PORCH   = DEF_VER_FRONT_PORCH,
  parameter int VER_SYNC          = DEF_VER_SYNC,
  parameter int VER_BACK_PORCH    = DEF_VER_BACK_PORCH
) (
  input  logic clk,
  input  logic rst_n,
  output logic visible,
  output logic in_hsync,
  output logic in_vsync,
  output logic frame_first,
  output logic frame_last
);

  localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT        = HW'(HOR_ACTIVE_PIXELS);
  localparam logic [VW-1:0] V_ACT        = VW'(VER_ACTIVE_PIXELS);
  localparam logic [HW-1:0] H_SYNC_START = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC);
  localparam logic [VW-1:0] V_SYNC_START = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign visible     = (h < H_ACT) && (v < V_ACT);
  assign in_hsync    = (h >= H_SYNC_START) && (h < H_SYNC_END);
  assign in_vsync    = (v >= V_SYNC_START) && (v < V_SYNC_END);
  assign frame_first = (h == '0) && (v == '0);
  assign frame_last  = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/frame_scanout.sv
// frame_scanout
// Display-side reader of the double-buffered 1-bit frame buffer.
// Ports:
//   clk, rst_n    : pixel clock, asynchronous active-low reset
//   read_addr     : frame buffer read address (raster order, running counter)
//   read_data     : frame buffer pixel, valid one cycle after read_addr
//   swap          : one-cycle buffer toggle strobe to the frame buffer
//   swap_request  : renderer level asking for a swap at the next frame end
//   swap_ack      : one-cycle acknowledge, coincident with swap
//   hsync, vsync  : active-low sync outputs
//   active        : pixel is inside the visible area
//   pixel         : output pixel, 0 outside the visible area
//   frame_start   : one-cycle pulse aligned with output pixel (0,0)
// Stage 0 holds the raster counters and read_addr, stage 1 is the memory
// read, stage 2 registers every display output, so all display outputs lag
// the counter position by exactly two cycles and stay mutually aligned.
module frame_scanout
  import vga_timing_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE_PIXELS,
  parameter int VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
  parameter int HOR_FRONT_PORCH   = DEF_HOR_FRONT_PORCH,
  parameter int HOR_SYNC          = DEF_HOR_SYNC,
  parameter int HOR_BACK_PORCH    = DEF_HOR_BACK_PORCH,
  parameter int VER_FRONT_PORCH   = DEF_VER_FRONT_PORCH,
  parameter int VER_SYNC          = DEF_VER_SYNC,
  parameter int VER_BACK_PORCH    = DEF_VER_BACK_PORCH,
  localparam int ADDR_WIDTH       = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_data,
  output logic                  swap,
  input  logic                  swap_request,
  output logic                  swap_ack,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  active,
  output logic                  pixel,
  output logic                  frame_start
);

  logic visible;
  logic in_hsync;
  logic in_vsync;
  logic frame_first;
  logic frame_last;

  vga_counter #(
    .HOR_ACTIVE_PIXELS(HOR_ACTIVE_PIXELS),
    .VER_ACTIVE_PIXELS(VER_ACTIVE_PIXELS),
    .HOR_FRONT_PORCH  (HOR_FRONT_PORCH),
    .HOR_SYNC         (HOR_SYNC),
    .HOR_BACK_PORCH   (HOR_BACK_PORCH),
    .VER_FRONT_PORCH  (VER_FRONT_PORCH),
    .VER_SYNC         (VER_SYNC),
    .VER_BACK_PORCH   (VER_BACK_PORCH)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .visible    (visible),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .frame_first(frame_first),
    .frame_last (frame_last)
  );

  // Running raster address: advances only after visible cycles and holds in
  // blanking. Reloading on the last frame cycle puts it at 0 together with
  // the counters landing on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_addr <= '0;
    end else if (frame_last) begin
      read_addr <= '0;
    end else if (visible) begin
      read_addr <= read_addr + 1'b1;
    end
  end

  // Stage 1: region flags delayed to line up with read_data.
  logic visible_s1;
  logic hsync_s1;
  logic vsync_s1;
  logic first_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visible_s1 <= 1'b0;
      hsync_s1   <= 1'b0;
      vsync_s1   <= 1'b0;
      first_s1   <= 1'b0;
    end else begin
      visible_s1 <= visible;
      hsync_s1   <= in_hsync;
      vsync_s1   <= in_vsync;
      first_s1   <= frame_first;
    end
  end

  // Stage 2: registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel       <= 1'b0;
      active      <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      frame_start <= 1'b0;
    end else begin
      pixel       <= read_data & visible_s1;
      active      <= visible_s1;
      hsync       <= hsync_s1 ? SYNC_ACTIVE : SYNC_IDLE;
      vsync       <= vsync_s1 ? SYNC_ACTIVE : SYNC_IDLE;
      frame_start <= first_s1;
    end
  end

  // The swap strobe is decoded from the registered counter state and is high
  // for the whole last frame cycle, so the buffer toggles at the edge that
  // moves stage 0 to (0,0): address 0 of the new frame already reads the new
  // buffer. The request is sampled in that same cycle, so a request that
  // rises on the last cycle still counts. Only one such cycle exists per
  // frame, which bounds swaps to one per frame.
  assign swap     = frame_last & swap_request;
  assign swap_ack = swap;

endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout
// Directed bench for frame_scanout with reduced 4x3 timing (all porch and
// sync widths 1): H_TOTAL=7, V_TOTAL=6, 42 cycles per frame.
// k counts clock edges since reset release; stage 0 sits at raster position
// k mod 42 and the display outputs show position k-2.
module tb_frame_scanout;

  localparam int HA = 4;
  localparam int VA = 3;
  localparam int HT = 7;
  localparam int VT = 6;
  localparam int FT = HT * VT;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read_data = 1'b1;
  logic          swap_request = 1'b0;
  logic [AW-1:0] read_addr;
  logic          swap;
  logic          swap_ack;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          pixel;
  logic          frame_start;

  frame_scanout #(
    .HOR_ACTIVE_PIXELS(HA),
    .VER_ACTIVE_PIXELS(VA),
    .HOR_FRONT_PORCH  (1),
    .HOR_SYNC         (1),
    .HOR_BACK_PORCH   (1),
    .VER_FRONT_PORCH  (1),
    .VER_SYNC         (1),
    .VER_BACK_PORCH   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .swap        (swap),
    .swap_request(swap_request),
    .swap_ack    (swap_ack),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .pixel       (pixel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int k       = 0;

  int swap_count;
  int ack_count;
  int swap_bad_pos;
  int spacing_bad;
  int last_swap_k;
  int act_cnt;
  int pix_cnt;
  int hs_cnt;
  int vs_cnt;
  int fs_cnt;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_total++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (k=%0d)", tag, obs, exp_v, k);
  endtask

  task automatic clear_counts();
    swap_count   = 0;
    ack_count    = 0;
    swap_bad_pos = 0;
    spacing_bad  = 0;
    last_swap_k  = -1;
    act_cnt      = 0;
    pix_cnt      = 0;
    hs_cnt       = 0;
    vs_cnt       = 0;
    fs_cnt       = 0;
  endtask

  // One clock: compare read_addr and the display outputs against the raster
  // position they should reflect, and tally pulses for window checks.
  task automatic step();
    int p, h, v, j, jh, jv, ea;
    int e_act, e_hs, e_vs, e_fs;
    @(posedge clk);
    #1;
    k++;
    p  = k % FT;
    h  = p % HT;
    v  = p / HT;
    ea = (v < VA) ? v * HA + ((h < HA) ? h : HA) : HA * VA;
    check("read_addr", int'(read_addr), ea);
    if (k >= 2) begin
      j     = (k - 2) % FT;
      jh    = j % HT;
      jv    = j / HT;
      e_act = (jh < HA && jv < VA) ? 1 : 0;
      e_hs  = (jh == HA + 1) ? 0 : 1;
      e_vs  = (jv == VA + 1) ? 0 : 1;
      e_fs  = (j == 0) ? 1 : 0;
    end else begin
      e_act = 0;
      e_hs  = 1;
      e_vs  = 1;
      e_fs  = 0;
    end
    check("active", int'(active), e_act);
    check("pixel", int'(pixel), e_act);
    check("hsync", int'(hsync), e_hs);
    check("vsync", int'(vsync), e_vs);
    check("frame_start", int'(frame_start), e_fs);
    if (active) act_cnt++;
    if (pixel) pix_cnt++;
    if (!hsync) hs_cnt++;
    if (!vsync) vs_cnt++;
    if (frame_start) fs_cnt++;
    if (swap_ack) ack_count++;
    if (swap) begin
      swap_count++;
      $display("swap pulse at k=%0d, raster pos %0d", k, p);
      if (p != FT - 1) swap_bad_pos++;
      if (last_swap_k >= 0 && (k - last_swap_k) != FT) spacing_bad++;
      last_swap_k = k;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_read_addr"}, int'(read_addr), 0);
    check({tag, "_active"}, int'(active), 0);
    check({tag, "_pixel"}, int'(pixel), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_swap"}, int'(swap), 0);
    check({tag, "_swap_ack"}, int'(swap_ack), 0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");

    // Release between edges; the first edge after this is k=1.
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    #1;
    check("rel_read_addr", int'(read_addr), 0);

    // Two frames of plain scanout.
    clear_counts();
    repeat (2 * FT) step();
    check("scan_active_cnt", act_cnt, 2 * HA * VA - 0);
    check("scan_pixel_cnt", pix_cnt, 24);
    check("scan_hsync_low", hs_cnt, 12);
    check("scan_vsync_low", vs_cnt, 14);
    check("scan_frame_start", fs_cnt, 2);
    check("scan_no_swap", swap_count, 0);
    $display("phase scan done, k=%0d", k);

    // Request held for three frames.
    swap_request = 1'b1;
    clear_counts();
    repeat (3 * FT) step();
    swap_request = 1'b0;
    check("held_swap_cnt", swap_count, 3);
    check("held_ack_cnt", ack_count, 3);
    check("held_swap_pos", swap_bad_pos, 0);
    check("held_swap_spacing", spacing_bad, 0);
    check("held_active_cnt", act_cnt, 36);
    check("held_hsync_low", hs_cnt, 18);
    check("held_vsync_low", vs_cnt, 21);
    check("held_frame_start", fs_cnt, 3);
    $display("phase held-request done, k=%0d", k);

    // One-cycle request mid-frame: no swap at the following frame end.
    clear_counts();
    repeat (20) step();
    swap_request = 1'b1;
    step();
    swap_request = 1'b0;
    repeat (21) step();
    check("pulse_no_swap", swap_count, 0);
    check("pulse_no_ack", ack_count, 0);
    $display("phase pulse-request done, k=%0d", k);

    // Request rising during the last frame cycle is honoured in that cycle.
    repeat (FT - 1) step();
    check("late_pos", k % FT, FT - 1);
    check("late_swap_before", int'(swap), 0);
    swap_request = 1'b1;
    #1;
    check("late_swap", int'(swap), 1);
    check("late_swap_ack", int'(swap_ack), 1);
    swap_request = 1'b0;
    #1;
    check("late_swap_drop", int'(swap), 0);
    step();
    $display("phase late-request done, k=%0d", k);

    // Reset in the middle of line 1.
    repeat (9) step();
    check("midrst_addr_before", int'(read_addr), 6);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    #1;
    check("midrst_rel_addr", int'(read_addr), 0);
    clear_counts();
    step();
    check("midrst_fs_k1", int'(frame_start), 0);
    step();
    check("midrst_fs_k2", int'(frame_start), 1);
    check("midrst_active_k2", int'(active), 1);
    repeat (FT) step();
    check("midrst_frame_start_cnt", fs_cnt, 2);
    $display("phase mid-reset done, k=%0d", k);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
